// File: rtl/fc_pkg.sv
// Shared types and widths for the fully-connected layer sequencer.
// Default geometry matches the reference network: 10 neurons x 100 weights.
package fc_pkg;

  localparam int unsigned FC_NEURON_NUM   = 10;
  localparam int unsigned FC_WEIGHT_DIM   = 100;
  localparam int unsigned FC_READ_LATENCY = 1;

  // Address width for v entries, never narrower than one bit.
  function automatic int unsigned fc_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int unsigned FC_ROM_AW  = fc_width(FC_NEURON_NUM * FC_WEIGHT_DIM);
  localparam int unsigned FC_FEAT_AW = fc_width(FC_WEIGHT_DIM);
  localparam int unsigned FC_IDX_W   = fc_width(FC_NEURON_NUM);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StDrain   = 2'd2,
    StWaitOut = 2'd3
  } fc_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } fc_issue_t;

endpackage

// File: rtl/fc_issue_pipe.sv
// Delays the {valid, first, last} issue tag by the memory read latency so the
// MAC control lines up with the weight/feature data.
module fc_issue_pipe
  import fc_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  fc_issue_t issue_i,
  output fc_issue_t issue_o
);

  fc_issue_t stage_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= issue_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign issue_o = stage_q[Depth-1];

endmodule

// File: rtl/fc_layer_ctrl.sv
// FC layer sequencer: walks the neuron-major weight ROM and the feature buffer
// in lockstep, drives latency-aligned MAC control and a per-neuron result handshake.
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int unsigned NEURON_NUM   = FC_NEURON_NUM,
  parameter int unsigned WEIGHT_DIM   = FC_WEIGHT_DIM,
  parameter int unsigned READ_LATENCY = FC_READ_LATENCY,
  localparam int unsigned RomAw  = fc_width(NEURON_NUM * WEIGHT_DIM),
  localparam int unsigned FeatAw = fc_width(WEIGHT_DIM),
  localparam int unsigned IdxW   = fc_width(NEURON_NUM)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_en_o,
  output logic [RomAw-1:0]  rom_addr_o,
  output logic              feat_rd_en_o,
  output logic [FeatAw-1:0] feat_addr_o,
  output logic              mac_valid_o,
  output logic              mac_clear_o,
  output logic              mac_last_o,
  output logic              out_valid_o,
  output logic [IdxW-1:0]   out_idx_o,
  input  logic              out_ready_i
);

  localparam int unsigned       DrainW    = fc_width(READ_LATENCY + 1);
  localparam logic [FeatAw-1:0] KLast     = FeatAw'(WEIGHT_DIM - 1);
  localparam logic [IdxW-1:0]   NLast     = IdxW'(NEURON_NUM - 1);
  localparam logic [DrainW-1:0] DrainInit = DrainW'(READ_LATENCY);

  fc_state_e         state_q, state_d;
  logic [IdxW-1:0]   n_q, n_d;
  logic [FeatAw-1:0] k_q, k_d;
  logic [RomAw-1:0]  addr_q, addr_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              issue_q, issue_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;

  fc_issue_t         pipe_in, pipe_out;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          n_d     = '0;
          k_d     = '0;
          addr_d  = '0;
        end
      end
      StRun: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          drain_d = DrainInit;
        end else begin
          k_d    = k_q + FeatAw'(1);
          addr_d = addr_q + RomAw'(1);
        end
      end
      StDrain: begin
        drain_d = drain_q - DrainW'(1);
        if (drain_q == DrainW'(1)) begin
          state_d = StWaitOut;
        end
      end
      StWaitOut: begin
        if (out_ready_i) begin
          if (n_q == NLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            // The flat address sits on the previous neuron's last weight.
            state_d = StRun;
            n_d     = n_q + IdxW'(1);
            k_d     = '0;
            addr_d  = addr_q + RomAw'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so every output comes from a flop.
  always_comb begin
    busy_d      = (state_d != StIdle);
    issue_d     = (state_d == StRun);
    first_d     = issue_d && (k_d == '0);
    last_d      = issue_d && (k_d == KLast);
    out_valid_d = (state_d == StWaitOut);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      n_q         <= '0;
      k_q         <= '0;
      addr_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issue_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      issue_q     <= issue_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pipe_in = '{valid: issue_q, first: first_q, last: last_q};

  fc_issue_pipe #(
    .Depth (READ_LATENCY)
  ) u_issue_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .issue_i (pipe_in),
    .issue_o (pipe_out)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rom_en_o     = issue_q;
  assign feat_rd_en_o = issue_q;
  assign rom_addr_o   = addr_q;
  assign feat_addr_o  = k_q;
  assign mac_valid_o  = pipe_out.valid;
  assign mac_clear_o  = pipe_out.first;
  assign mac_last_o   = pipe_out.last;
  assign out_valid_o  = out_valid_q;
  assign out_idx_o    = n_q;

endmodule
